// File: rtl/dcache_miss_ctrl.sv
// Two-way data cache controller: hit/miss lookup, write-through stores, 8-word load refill.
// Latency: hits and stores complete the same cycle; a load miss stalls for at least 10 cycles plus memory return latency.
// Backpressure: stall holds the CPU request; memory accepts one request per cycle, and read returns may arrive at any later time.
module dcache_miss_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [7:0]  tag_out_0,
    input  logic [7:0]  tag_out_1,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [63:0] block_en,
    output logic [7:0]  word,
    output logic        write_en_0,
    output logic        write_en_1,
    output logic        data_wen,
    output logic        tag_wen,
    output logic [15:0] data_in,
    output logic [7:0]  tag_in_0,
    output logic [7:0]  tag_in_1,
    output logic        stall,
    output logic        hit,
    output logic        hit_way,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata
);
    typedef enum logic [1:0] {IDLE, FILL, TAG_WR} state_t;

    state_t      state, state_nxt;
    logic [3:0]  issue_cnt, issue_cnt_nxt;
    logic [3:0]  recv_cnt, recv_cnt_nxt;
    logic        victim, victim_nxt;
    logic [5:0]  tag_r, tag_r_nxt;
    logic [5:0]  index_r, index_r_nxt;
    logic [63:0] lru;
    logic        lru_we, lru_val;
    logic [5:0]  lru_idx;
    logic        hit_0, hit_1;
    logic        unused_bits;

    // Metadata bit 6 is always zero and the address byte offset is never used.
    assign unused_bits = ^{tag_out_0[6], tag_out_1[6], req_addr[0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            issue_cnt <= 4'd0;
            recv_cnt  <= 4'd0;
            victim    <= 1'b0;
            tag_r     <= 6'd0;
            index_r   <= 6'd0;
            lru       <= '0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_cnt_nxt;
            recv_cnt  <= recv_cnt_nxt;
            victim    <= victim_nxt;
            tag_r     <= tag_r_nxt;
            index_r   <= index_r_nxt;
            if (lru_we) begin
                lru[lru_idx] <= lru_val;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        issue_cnt_nxt = issue_cnt;
        recv_cnt_nxt  = recv_cnt;
        victim_nxt    = victim;
        tag_r_nxt     = tag_r;
        index_r_nxt   = index_r;
        lru_we        = 1'b0;
        lru_val       = 1'b0;
        lru_idx       = req_addr[9:4];
        block_en      = 64'd0;
        word          = 8'd0;
        write_en_0    = 1'b0;
        write_en_1    = 1'b0;
        data_wen      = 1'b0;
        tag_wen       = 1'b0;
        data_in       = 16'd0;
        tag_in_0      = 8'd0;
        tag_in_1      = 8'd0;
        stall         = 1'b0;
        hit           = 1'b0;
        hit_way       = 1'b0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = 16'd0;
        mem_wdata     = 16'd0;
        hit_0         = tag_out_0[7] && (tag_out_0[5:0] == req_addr[15:10]);
        hit_1         = tag_out_1[7] && (tag_out_1[5:0] == req_addr[15:10]);

        case (state)
            IDLE: begin
                block_en = 64'd1 << req_addr[9:4];
                word     = 8'd1 << req_addr[3:1];
                hit      = req_valid && (hit_0 || hit_1);
                // A double hit resolves to way 0.
                hit_way  = hit_1 && !hit_0;
                if (req_valid && req_write) begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = req_addr;
                    mem_wdata = req_wdata;
                    if (hit) begin
                        write_en_0 = !hit_way;
                        write_en_1 = hit_way;
                        data_wen   = 1'b1;
                        data_in    = req_wdata;
                        lru_we     = 1'b1;
                        lru_val    = !hit_way;
                    end
                end else if (req_valid && hit) begin
                    lru_we  = 1'b1;
                    lru_val = !hit_way;
                end else if (req_valid) begin
                    stall         = 1'b1;
                    victim_nxt    = !tag_out_0[7] ? 1'b0 :
                                    (!tag_out_1[7] ? 1'b1 : lru[req_addr[9:4]]);
                    tag_r_nxt     = req_addr[15:10];
                    index_r_nxt   = req_addr[9:4];
                    issue_cnt_nxt = 4'd0;
                    recv_cnt_nxt  = 4'd0;
                    state_nxt     = FILL;
                end
            end
            FILL: begin
                stall    = 1'b1;
                block_en = 64'd1 << index_r;
                if (!issue_cnt[3]) begin
                    mem_en        = 1'b1;
                    mem_addr      = {tag_r, index_r, issue_cnt[2:0], 1'b0};
                    issue_cnt_nxt = issue_cnt + 4'd1;
                end
                if (mem_rvalid) begin
                    word         = 8'd1 << recv_cnt[2:0];
                    data_wen     = 1'b1;
                    data_in      = mem_rdata;
                    write_en_0   = !victim;
                    write_en_1   = victim;
                    recv_cnt_nxt = recv_cnt + 4'd1;
                    if (recv_cnt == 4'd7) begin
                        state_nxt = TAG_WR;
                    end
                end
            end
            TAG_WR: begin
                stall      = 1'b1;
                block_en   = 64'd1 << index_r;
                tag_wen    = 1'b1;
                write_en_0 = !victim;
                write_en_1 = victim;
                if (victim) begin
                    tag_in_1 = {2'b10, tag_r};
                end else begin
                    tag_in_0 = {2'b10, tag_r};
                end
                lru_we    = 1'b1;
                lru_idx   = index_r;
                lru_val   = !victim;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: models the cache arrays and an in-order memory with variable latency,
// and compares the controller against a two-way set/LRU reference kept as plain arrays.
module tb_dcache_miss_ctrl;
    logic        clk, rst;
    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  tag_out_0, tag_out_1;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [63:0] block_en;
    logic [7:0]  word;
    logic        write_en_0, write_en_1, data_wen, tag_wen;
    logic [15:0] data_in;
    logic [7:0]  tag_in_0, tag_in_1;
    logic        stall, hit, hit_way, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;

    dcache_miss_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .tag_out_0(tag_out_0), .tag_out_1(tag_out_1),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .block_en(block_en), .word(word),
        .write_en_0(write_en_0), .write_en_1(write_en_1), .data_wen(data_wen), .tag_wen(tag_wen),
        .data_in(data_in), .tag_in_0(tag_in_0), .tag_in_1(tag_in_1), .stall(stall), .hit(hit),
        .hit_way(hit_way), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Cache arrays, memory and read-return queue.
    logic [15:0] dm [2][64][8];
    logic [7:0]  tm [2][64];
    logic [15:0] mem [32768];
    logic [15:0] rq_addr [$];
    int          rq_due [$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    logic        tbl_mode = 1'b1;
    logic [7:0]  tbl_t0 = 8'd0, tbl_t1 = 8'd0;

    always_comb begin
        tag_out_0 = tbl_mode ? tbl_t0 : tm[0][req_addr[9:4]];
        tag_out_1 = tbl_mode ? tbl_t1 : tm[1][req_addr[9:4]];
    end

    logic        s_rst, s_en, s_wr, s_dwen, s_twen, s_we0, s_we1;
    logic [15:0] s_addr, s_wdata, s_din;
    logic [63:0] s_blk;
    logic [7:0]  s_word, s_tin0, s_tin1;

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'd0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 40503) ^ 16'h1234;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++) begin
                tm[w][s] = 8'd0;
                for (int k = 0; k < 8; k++) dm[w][s][k] = 16'd0;
            end
        forever begin
            @(negedge clk);
            s_rst = rst; s_en = mem_en; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_wdata;
            s_dwen = data_wen; s_twen = tag_wen; s_we0 = write_en_0; s_we1 = write_en_1;
            s_blk = block_en; s_word = word; s_din = data_in; s_tin0 = tag_in_0; s_tin1 = tag_in_1;
            @(posedge clk);
            cyc++;
            if (!s_rst) begin
                for (int s = 0; s < 64; s++) begin tm[0][s] = 8'd0; tm[1][s] = 8'd0; end
                rq_addr.delete();
                rq_due.delete();
            end else begin
                for (int i = 0; i < 64; i++) if (s_blk[i]) begin
                    if (s_dwen)
                        for (int k = 0; k < 8; k++) if (s_word[k]) begin
                            if (s_we0) dm[0][i][k] = s_din;
                            if (s_we1) dm[1][i][k] = s_din;
                        end
                    if (s_twen) begin
                        if (s_we0) tm[0][i] = s_tin0;
                        if (s_we1) tm[1][i] = s_tin1;
                    end
                end
                if (s_en && s_wr) mem[s_addr[15:1]] = s_wdata;
                else if (s_en) begin
                    rq_addr.push_back(s_addr);
                    rq_due.push_back(cyc - 1 + int'($urandom_range(lat_max, lat_min)));
                end
            end
            #1;
            if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[rq_addr[0][15:1]];
                void'(rq_addr.pop_front());
                void'(rq_due.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 16'($urandom);
            end
        end
    end

    // Reference: per-set valid/tag of both ways and the way to evict next.
    logic       rv [2][64];
    logic [5:0] rt [2][64];
    logic       rl [64];

    task automatic ref_clear();
        for (int s = 0; s < 64; s++) begin rv[0][s] = 1'b0; rv[1][s] = 1'b0; rl[s] = 1'b0; end
    endtask

    logic        l_stall, l_men, l_mwr, l_we0, l_we1, l_dwen, l_tw_way;
    logic [7:0]  l_word, l_tw_val;
    logic [15:0] l_maddr, l_mwd;
    int          l_nst;

    task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d);
        logic [5:0] ix, tg;
        logic eh0, eh1, eh, ew, vic, rd_ok, dat_ok;
        logic [1:0] tw_we;
        int n, nrd, ndw, bad_dw, tw_cnt;
        ix = a[9:4]; tg = a[15:10];
        eh0 = rv[0][ix] && rt[0][ix] == tg;
        eh1 = rv[1][ix] && rt[1][ix] == tg;
        eh = eh0 || eh1; ew = !eh0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        l_stall = stall; l_men = mem_en; l_mwr = mem_wr; l_we0 = write_en_0; l_we1 = write_en_1;
        l_dwen = data_wen; l_word = word; l_maddr = mem_addr; l_mwd = mem_wdata;
        l_nst = 0; l_tw_val = 8'd0; l_tw_way = 1'b0;
        chk("lookup_hit", hit, eh);
        if (eh) chk("lookup_way", hit_way, ew);
        if (w) begin
            chk("store", {stall, mem_en, mem_wr, mem_addr, mem_wdata, data_wen, write_en_0, write_en_1, tag_wen},
                {1'b0, 1'b1, 1'b1, a, d, eh, eh && !ew, eh && ew, 1'b0});
            if (eh) rl[ix] = !ew;
        end else if (eh) begin
            chk("load_hit_quiet", {stall, mem_en, data_wen, tag_wen}, 4'b0);
            rl[ix] = !ew;
        end else begin
            vic = !rv[0][ix] ? 1'b0 : (!rv[1][ix] ? 1'b1 : rl[ix]);
            n = 0; nrd = 0; ndw = 0; bad_dw = 0; tw_cnt = 0; rd_ok = 1'b1; tw_we = 2'b00;
            while (stall && n < 400) begin
                if (mem_en && !mem_wr) begin
                    if (mem_addr != {tg, ix, 3'(nrd), 1'b0}) rd_ok = 1'b0;
                    nrd++;
                end
                if (data_wen) begin
                    if (write_en_0 == !vic && write_en_1 == vic && block_en == (64'd1 << ix)) ndw++;
                    else bad_dw++;
                end
                if (tag_wen) begin
                    tw_cnt++; tw_we = {write_en_0, write_en_1};
                    l_tw_way = write_en_1; l_tw_val = write_en_1 ? tag_in_1 : tag_in_0;
                end
                n++;
                @(negedge clk);
            end
            l_nst = n;
            if (lat_min == lat_max) chk("miss_penalty", n, lat_min + 10);
            chk("fill_reads", {nrd, rd_ok}, {32'd8, 1'b1});
            chk("fill_data_writes", {ndw, bad_dw}, {32'd8, 32'd0});
            chk("tag_write", {tw_cnt, tw_we, l_tw_val}, {32'd1, vic ? 2'b01 : 2'b10, 2'b10, tg});
            chk("refill_hit", {stall, hit, hit_way}, {1'b0, 1'b1, vic});
            dat_ok = 1'b1;
            for (int k = 0; k < 8; k++)
                if (dm[vic][ix][k] !== mem[{tg, ix, 3'(k)}]) dat_ok = 1'b0;
            chk("fill_block_data", dat_ok, 1'b1);
            rv[vic][ix] = 1'b1; rt[vic][ix] = tg; rl[ix] = !vic;
            ew = vic;
        end
        if (!w) chk("load_data", dm[ew][ix][a[3:1]], mem[a[15:1]]);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    typedef struct {
        logic v, w; logic [15:0] a, d; logic [7:0] t0, t1;
        logic e_hit, e_way, e_stall, e_we0, e_we1, e_dwen, e_men;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, tw, n;
        logic [15:0] a;
        tbl[0] = '{0, 0, 16'h0412, 16'h0000, 8'h81, 8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 16'h0412, 16'h0000, 8'h81, 8'h00, 1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 16'h0412, 16'h0000, 8'h00, 8'h81, 1, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 16'h0412, 16'h0000, 8'h81, 8'h81, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 0, 16'h0412, 16'h0000, 8'h01, 8'h02, 0, 0, 1, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 16'h0414, 16'hBEEF, 8'h81, 8'h00, 1, 0, 0, 1, 0, 1, 1};
        tbl[6] = '{1, 1, 16'h2000, 16'h1234, 8'h81, 8'h82, 0, 0, 0, 0, 0, 0, 1};
        tbl[7] = '{1, 1, 16'hFC1E, 16'h5A5A, 8'h00, 8'hBF, 1, 1, 0, 0, 1, 1, 1};
        tbl[8] = '{1, 0, 16'hFFF0, 16'h0000, 8'hBF, 8'h00, 1, 0, 0, 0, 0, 0, 0};
        tbl[9] = '{1, 1, 16'h0000, 16'h7777, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1};

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0; req_wdata = 16'd0;
        ref_clear();
        @(posedge clk); @(negedge clk);
        chk("reset_state", {stall, hit, mem_en, data_wen, tag_wen, write_en_0, write_en_1}, 7'd0);

        // Lookup decode vectors, applied while reset holds the controller in IDLE.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            req_valid = tbl[i].v; req_write = tbl[i].w; req_addr = tbl[i].a; req_wdata = tbl[i].d;
            tbl_t0 = tbl[i].t0; tbl_t1 = tbl[i].t1;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {hit, hit_way, stall, write_en_0, write_en_1, data_wen, tag_wen, mem_en, mem_wr, word, block_en, data_in},
                {tbl[i].e_hit, tbl[i].e_way, tbl[i].e_stall, tbl[i].e_we0, tbl[i].e_we1, tbl[i].e_dwen, 1'b0,
                 tbl[i].e_men, tbl[i].e_men, 8'd1 << tbl[i].a[3:1], 64'd1 << tbl[i].a[9:4],
                 tbl[i].e_dwen ? tbl[i].d : 16'd0});
            if (tbl[i].e_men) chk($sformatf("vec%0d_mem", i), {mem_addr, mem_wdata}, {tbl[i].a, tbl[i].d});
        end
        @(posedge clk); #1;
        req_valid = 1'b0; tbl_mode = 1'b0; rst = 1'b1;

        // Cold load miss, then store hit, then same-set fills and eviction.
        lat_min = 1; lat_max = 1;
        do_access(1'b0, 16'h0412, 16'h0);
        chk("cold_fill_tag", {l_tw_way, l_tw_val, l_nst}, {1'b0, 8'h81, 32'd11});
        do_access(1'b1, 16'h0414, 16'hBEEF);
        chk("store_hit_strobes", {l_we0, l_dwen, l_word, l_stall, l_men, l_mwr, l_maddr, l_mwd},
            {1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 16'h0414, 16'hBEEF});
        chk("store_hit_array", {dm[0][1][2], mem[15'h020A]}, {16'hBEEF, 16'hBEEF});
        do_access(1'b0, 16'h0410, 16'h0);
        do_access(1'b0, 16'h0810, 16'h0);
        chk("second_way_fill", {l_tw_way, l_tw_val}, {1'b1, 8'h82});
        do_access(1'b0, 16'h0C10, 16'h0);
        chk("evict_way0", {l_tw_way, l_tw_val}, {1'b0, 8'h83});
        do_access(1'b1, 16'h2000, 16'h1111);
        chk("store_miss_no_fill", {l_we0, l_we1, l_dwen, l_men, l_mwr}, 5'b00011);
        do_access(1'b0, 16'h0810, 16'h0);
        do_access(1'b1, 16'h2010, 16'h2222);
        do_access(1'b0, 16'h1010, 16'h0);
        chk("lru_kept_after_store_miss", l_tw_way, 1'b0);

        // Reset part-way through a fill.
        lat_min = 4; lat_max = 4;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1420;
        @(negedge clk);
        chk("abort_miss_stall", stall, 1'b1);
        cnt = 0; tw = 0; n = 0;
        while (cnt < 3 && n < 200) begin
            @(negedge clk);
            if (data_wen) cnt++;
            if (tag_wen) tw++;
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle", {cnt, tw, stall, tag_wen, data_wen, mem_en}, {32'd3, 32'd0, 4'd0});
        ref_clear();
        do_access(1'b0, 16'h1420, 16'h0);
        chk("refill_after_abort", {l_tw_way, l_tw_val}, {1'b0, 8'h85});

        // Random traffic over a few sets and tags.
        lat_min = 1; lat_max = 6;
        for (int i = 0; i < 150; i++) begin
            a = {6'($urandom_range(4, 0)), 6'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 1'b0};
            do_access($urandom_range(9, 0) < 3, a, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
